ddr_reader: RTL and testbench
=============================

DDR_READER -- requirements
Module: ddr_reader

Interface
REQ-001 SHALL have parameter N_KERNEL, default 4, channels per output beat.
REQ-002 SHALL have parameter B_PIXEL, default 16, bits per channel value.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, read-data width, equal to N_KERNEL*B_PIXEL.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, DDR byte-address width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, read-data buffer entries, a power of 2.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins a tensor read; ignored unless idle.
REQ-009 SHALL have port base_addr  in  32  tensor byte base address, sampled on accepted start.
REQ-010 SHALL have port shape  in  32  w=[9:0], h=[19:10], c=[31:20], sampled on accepted start.
REQ-011 SHALL have port busy  out  1  high from accepted start until done.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last output beat is accepted.
REQ-013 SHALL have ports m_axis_tdata  out  ADDR_WIDTH, m_axis_tvalid  out  1, m_axis_tready  in  1  read-request stream.
REQ-014 SHALL have ports s_axis_tdata  in  DATA_WIDTH, s_axis_tvalid  in  1, s_axis_tready  out  1  read-data stream returned in request order.
REQ-015 SHALL have ports dout_data  out  DATA_WIDTH, dout_valid  out  1, dout_ready  in  1  consumer stream.

Function
REQ-016 SHALL use FSM IDLE -> RUN on start, RUN -> DRAIN after the last request is accepted, DRAIN -> DONE when the last dout beat is accepted, and DONE -> IDLE after one cycle while pulsing done.
REQ-017 SHALL treat start with w, h or c equal to 0 as a request with no beats: IDLE -> DONE, no requests issued.
REQ-018 SHALL issue w*h*(c/N_KERNEL) requests, with c a multiple of N_KERNEL; behaviour for any other c is undefined.
REQ-019 SHALL order requests so that the outer loop runs over channel groups dc = 0, N_KERNEL*(B_PIXEL/8), ..., and the inner loop runs over w*h pixels with stride c*(B_PIXEL/8) bytes.
REQ-020 SHALL compute each request address as base_addr + dxy + dc, modulo 2^ADDR_WIDTH, with wrap-around permitted.
REQ-021 SHALL hold the current request's address and m_axis_tvalid stable until m_axis_tready, and advance to the next address only on handshake.
REQ-022 SHALL issue a request only when outstanding + fifo_count < FIFO_DEPTH, so that returned data never overflows the FIFO.
REQ-023 SHALL drive s_axis_tready = 1 while busy.
REQ-024 SHALL drop, and leave uncounted, any s_axis beat received while not busy.
REQ-025 SHALL increment outstanding on a request handshake, decrement it on a data handshake, and leave it unchanged when both occur in the same cycle.
REQ-026 SHALL present dout from the FIFO head, with dout_valid = FIFO not empty.
REQ-027 SHALL provide a latency from s_axis handshake to dout_valid of 1 cycle.
REQ-028 SHALL support a simultaneous FIFO push and pop without changing the FIFO count.
REQ-029 SHALL ignore start while busy.

Reset
REQ-030 SHALL, on rst, set the FSM to IDLE, empty the FIFO, and clear outstanding and all counters.
REQ-031 SHALL drive these outputs to 0 while rst is asserted and in the first cycle after it: busy, done, m_axis_tvalid, m_axis_tdata, s_axis_tready, dout_valid, dout_data.
REQ-032 SHALL abort a read on rst mid-operation with no done pulse; a subsequent start begins cleanly.

Configuration
REQ-033 SHALL add output dout_last (1 bit) when DDR_READER_LAST_EN is defined, high with dout_valid on the final beat of a tensor and 0 at reset.
REQ-034 SHALL omit dout_last when DDR_READER_LAST_EN is undefined, with all other behaviour identical.

Verification
REQ-035 SHALL verify: base_addr=0x1000, w=2, h=1, c=8, tready=1, zero-latency responder -> requests 0x1000, 0x1010, 0x1008, 0x1018; 4 dout beats in order; one done pulse.
REQ-036 SHALL verify: shape=0 start -> zero requests; done pulses within 2 cycles of start; busy high at most 2 cycles.
REQ-037 SHALL verify: w=16, h=1, c=4, dout_ready=0, responder returns data immediately -> at most 8 requests accepted; requests resume after dout_ready=1; 16 beats total.
REQ-038 SHALL verify: m_axis_tready toggling randomly -> m_axis_tdata stable while valid and not ready; address sequence unchanged.
REQ-039 SHALL verify: base_addr=0xFFFFFFF8, w=2, h=1, c=4 -> requests 0xFFFFFFF8, 0x00000000.
REQ-040 SHALL verify: rst asserted after 3 of 8 beats -> all outputs 0, no done pulse; restart completes the full 8-beat sequence.

Source files
------------

// File: rtl/ddr_reader.sv
// ddr_reader: streams a channel-grouped tensor out of DDR as N_KERNEL-channel beats.
// Build option DDR_READER_LAST_EN adds a dout_last output that marks the final beat.
module ddr_reader #(
    parameter int N_KERNEL   = 4,
    parameter int B_PIXEL    = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           shape,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready
`ifdef DDR_READER_LAST_EN
    ,
    output logic                  dout_last
`endif
);
    // Every stream uses valid/ready: a beat transfers on a rising edge where both are
    // high, and the source holds data and valid stable until that edge.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PIX_BYTES = ADDR_WIDTH'(B_PIXEL / 8);
    localparam logic [ADDR_WIDTH-1:0] GRP_STEP  = ADDR_WIDTH'(N_KERNEL * (B_PIXEL / 8));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_dc;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [19:0]           r_npix;
    logic [19:0]           r_pix;
    logic [11:0]           r_ngrp;
    logic [11:0]           r_grp;
    logic [31:0]           r_beats_left;
    logic [CNT_W-1:0]      r_outst;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wr;
    logic [PTR_W-1:0]      r_rd;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [9:0]            w_w;
    logic [9:0]            w_h;
    logic [11:0]           w_c;
    logic [19:0]           w_npix;
    logic [11:0]           w_ngrp;
    logic [31:0]           w_total;
    logic [ADDR_WIDTH-1:0] w_stride;
    logic                  w_empty_shape;
    logic                  w_busy;
    logic                  w_credit;
    logic                  w_req_hs;
    logic                  w_s_hs;
    logic                  w_push;
    logic                  w_dvalid;
    logic                  w_pop;
    logic                  w_last_pix;
    logic                  w_last_grp;

    assign w_w           = shape[9:0];
    assign w_h           = shape[19:10];
    assign w_c           = shape[31:20];
    assign w_npix        = {10'd0, w_w} * {10'd0, w_h};
    assign w_ngrp        = w_c / 12'(N_KERNEL);
    assign w_total       = {12'd0, w_npix} * {20'd0, w_ngrp};
    assign w_stride      = ADDR_WIDTH'(w_c) * PIX_BYTES;
    assign w_empty_shape = (w_w == 10'd0) || (w_h == 10'd0) || (w_ngrp == 12'd0);

    // Requests in flight plus buffered beats never exceed the buffer, so every
    // returned beat has a slot even with s_axis_tready tied high.
    assign w_credit   = ({1'b0, r_outst} + {1'b0, r_count}) < {1'b0, DEPTH_C};
    assign w_busy     = (r_state != S_IDLE) && !rst;
    assign w_req_hs   = m_axis_tvalid && m_axis_tready;
    assign w_s_hs     = s_axis_tvalid && w_busy;
    assign w_push     = w_s_hs && (r_count != DEPTH_C);
    assign w_dvalid   = (r_count != '0) && !rst;
    assign w_pop      = w_dvalid && dout_ready;
    assign w_last_pix = (r_pix == r_npix - 20'd1);
    assign w_last_grp = (r_grp == r_ngrp - 12'd1);

    assign busy          = w_busy;
    assign done          = (r_state == S_DONE) && !rst;
    assign s_axis_tready = w_busy;
    assign m_axis_tvalid = (r_state == S_RUN) && w_credit && !rst;
    assign m_axis_tdata  = m_axis_tvalid ? r_addr : '0;
    assign dout_valid    = w_dvalid;
    assign dout_data     = w_dvalid ? r_mem[r_rd] : '0;
`ifdef DDR_READER_LAST_EN
    assign dout_last     = w_dvalid && (r_beats_left == 32'd1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_stride     <= '0;
            r_dc         <= '0;
            r_addr       <= '0;
            r_npix       <= '0;
            r_pix        <= '0;
            r_ngrp       <= '0;
            r_grp        <= '0;
            r_beats_left <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base       <= base_addr;
                        r_addr       <= base_addr;
                        r_dc         <= '0;
                        r_stride     <= w_stride;
                        r_npix       <= w_npix;
                        r_ngrp       <= w_ngrp;
                        r_pix        <= '0;
                        r_grp        <= '0;
                        r_beats_left <= w_total;
                        r_state      <= w_empty_shape ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Pixels are the inner loop; a channel group restarts at base + dc.
                    if (w_req_hs) begin
                        if (w_last_pix) begin
                            r_pix  <= '0;
                            r_grp  <= r_grp + 12'd1;
                            r_dc   <= r_dc + GRP_STEP;
                            r_addr <= r_base + r_dc + GRP_STEP;
                            if (w_last_grp) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_pix  <= r_pix + 20'd1;
                            r_addr <= r_addr + r_stride;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_beats_left == 32'd1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_pop) begin
                r_beats_left <= r_beats_left - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst <= '0;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (w_req_hs && !w_s_hs) begin
                r_outst <= r_outst + CNT_ONE;
            end else if (!w_req_hs && w_s_hs && (r_outst != '0)) begin
                r_outst <= r_outst - CNT_ONE;
            end
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_ddr_reader.sv
// Bench for ddr_reader: randomized stimulus checked against a loop-level model of the
// request order, a request-order responder, and beat/done/busy expectations.
module tb_ddr_reader;
    localparam int N_KERNEL   = 4;
    localparam int B_PIXEL    = 16;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 32;
    localparam int FIFO_DEPTH = 8;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [31:0]           shape;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] dout_data;
    logic                  dout_valid;
    logic                  dout_ready;
`ifdef DDR_READER_LAST_EN
    logic                  dout_last;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic        m_active, done_next, stall_prev, dv_expect, rst_seen, start_req, spurious;
    logic [31:0] stall_addr;
    int          n_req, n_pop, done_cnt, busy_cnt;
    int          tready_mode, resp_mode, dr_mode;
    logic [31:0] exp_addr_q[$];
    logic [31:0] model_addrs[$];
    logic [31:0] dut_addr_log[$];
    logic [31:0] resp_q[$];
    logic [63:0] exp_dout_q[$];

    ddr_reader #(
        .N_KERNEL(N_KERNEL), .B_PIXEL(B_PIXEL), .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .shape(shape),
        .busy(busy), .done(done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef DDR_READER_LAST_EN
        , .dout_last(dout_last)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
        chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, "_dout_data"}, dout_data, 64'd0);
`ifdef DDR_READER_LAST_EN
        chk({tag, "_dout_last"}, 64'(dout_last), 64'd0);
`endif
    endtask

    function automatic logic [63:0] fdata(input logic [31:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [31:0] mk_shape(input int w, input int h, input int c);
        logic [31:0] s;
        s[9:0]   = 10'(w);
        s[19:10] = 10'(h);
        s[31:20] = 12'(c);
        return s;
    endfunction

    // Reference order: channel groups outer, pixels inner, byte addresses wrap at 32 bits.
    function automatic void build_expect(input logic [31:0] b, input logic [31:0] s);
        int w, h, c;
        w = int'(s[9:0]);
        h = int'(s[19:10]);
        c = int'(s[31:20]);
        exp_addr_q.delete();
        exp_dout_q.delete();
        model_addrs.delete();
        if (w == 0 || h == 0 || c == 0) return;
        for (int g = 0; g < c / N_KERNEL; g++) begin
            for (int p = 0; p < w * h; p++) begin
                logic [31:0] a;
                a = b + 32'(p * c * (B_PIXEL / 8)) + 32'(g * N_KERNEL * (B_PIXEL / 8));
                exp_addr_q.push_back(a);
                model_addrs.push_back(a);
                exp_dout_q.push_back(fdata(a));
            end
        end
    endfunction

    // One cycle: check outputs at the falling edge, pick new inputs, then account for
    // the handshakes that will happen on the next rising edge.
    task automatic step();
        logic m_hs, s_hs, d_hs, done_now;
        @(negedge clk);
        done_now  = done_next;
        done_next = 1'b0;
        if (rst) begin
            chk_all_zero("in_rst");
            m_active = 0; stall_prev = 0; dv_expect = 0; rst_seen = 1;
            n_req = 0; n_pop = 0;
            exp_addr_q.delete(); exp_dout_q.delete(); resp_q.delete();
            start = 0; start_req = 0; s_axis_tvalid = 0; s_axis_tdata = '0;
            return;
        end
        if (rst_seen) chk_all_zero("post_rst");
        rst_seen = 0;
        chk("busy", 64'(busy), 64'(m_active));
        chk("s_tready", 64'(s_axis_tready), 64'(m_active));
        chk("done", 64'(done), 64'(done_now));
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (!m_active) begin
            chk("idle_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            chk("idle_dout_valid", 64'(dout_valid), 64'd0);
        end
        if (stall_prev) begin
            chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("stall_tdata", 64'(m_axis_tdata), 64'(stall_addr));
        end
        if (dv_expect) chk("resp_latency", 64'(dout_valid), 64'd1);
`ifdef DDR_READER_LAST_EN
        chk("dout_last", 64'(dout_last), 64'(dout_valid && exp_dout_q.size() == 1));
`endif
        m_axis_tready = (tready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        dout_ready = (dr_mode == 0) ? 1'b0 : (dr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (spurious) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
        end else if (resp_q.size() > 0 && (resp_mode == 0 || $urandom_range(0, 1) == 1)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fdata(resp_q[0]);
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
        end
        start     = start_req;
        start_req = 0;
        m_hs = m_axis_tvalid && m_axis_tready;
        s_hs = s_axis_tvalid && s_axis_tready;
        d_hs = dout_valid && dout_ready;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_addr = m_axis_tdata;
        dv_expect  = s_hs;
        if (m_hs) begin
            chk("credit", 64'((n_req - n_pop) < FIFO_DEPTH), 64'd1);
            if (exp_addr_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL extra_req: got 0x%0h, expected no request", m_axis_tdata);
            end else begin
                chk("req_addr", 64'(m_axis_tdata), 64'(exp_addr_q.pop_front()));
            end
            dut_addr_log.push_back(m_axis_tdata);
            n_req++;
        end
        if (d_hs) begin
            if (exp_dout_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL extra_beat: got 0x%0h, expected no beat", dout_data);
            end else begin
                chk("dout_data", dout_data, exp_dout_q.pop_front());
                if (exp_dout_q.size() == 0 && exp_addr_q.size() == 0) done_next = 1'b1;
            end
            n_pop++;
        end
        if (s_hs) void'(resp_q.pop_front());
        if (m_hs) resp_q.push_back(m_axis_tdata);
        if (done_now) begin
            m_active = 0;
        end else if (start && !m_active) begin
            m_active = 1;
            n_req = 0; n_pop = 0;
            dut_addr_log.delete();
            build_expect(base_addr, shape);
            if (exp_addr_q.size() == 0) done_next = 1'b1;
        end
    endtask

    task automatic launch(input logic [31:0] b, input logic [31:0] s);
        base_addr = b;
        shape     = s;
        start_req = 1;
        step();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((m_active || done_next) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (m_active || done_next) begin
            n_errors++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    initial begin
        int dc0, k, w, h, c;
        logic [31:0] lit4[4];
        rst = 1; start = 0; base_addr = '0; shape = '0;
        m_axis_tready = 0; s_axis_tvalid = 0; s_axis_tdata = '0; dout_ready = 0;
        m_active = 0; done_next = 0; stall_prev = 0; dv_expect = 0; rst_seen = 0;
        start_req = 0; spurious = 0; stall_addr = '0;
        n_req = 0; n_pop = 0; done_cnt = 0; busy_cnt = 0;
        tready_mode = 0; resp_mode = 0; dr_mode = 1;
        #1;
        chk_all_zero("rst_first");
        repeat (3) step();
        rst = 0;
        step();

        // Two pixels, two channel groups, everything ready
        dc0 = done_cnt;
        launch(32'h1000, mk_shape(2, 1, 8));
        lit4 = '{32'h1000, 32'h1010, 32'h1008, 32'h1018};
        for (int i = 0; i < 4; i++) chk("model_t035", 64'(model_addrs[i]), 64'(lit4[i]));
        run_until_idle(200, "t035");
        chk("t035_nreq", 64'(dut_addr_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < dut_addr_log.size(); i++)
            chk("t035_addr", 64'(dut_addr_log[i]), 64'(lit4[i]));
        chk("t035_beats", 64'(n_pop), 64'd4);
        chk("t035_done", 64'(done_cnt - dc0), 64'd1);

        // Data arriving while idle is dropped
        spurious = 1;
        repeat (3) step();
        spurious = 0;
        step();
        chk("drop_dout_valid", 64'(dout_valid), 64'd0);

        // Empty shape completes without requests
        dc0 = done_cnt; busy_cnt = 0;
        launch(32'h2000, 32'd0);
        step(); step(); step();
        chk("t036_done", 64'(done_cnt - dc0), 64'd1);
        chk("t036_nreq", 64'(n_req), 64'd0);
        chk("t036_busy_le2", 64'(busy_cnt <= 2), 64'd1);

        // Consumer stalled: requests limited by the buffer, then resume
        dc0 = done_cnt;
        dr_mode = 0;
        launch(32'h3000, mk_shape(16, 1, 4));
        repeat (30) step();
        chk("t037_limit", 64'(n_req <= FIFO_DEPTH), 64'd1);
        chk("t037_some", 64'(n_req > 0), 64'd1);
        chk("t037_no_pop", 64'(n_pop), 64'd0);
        dr_mode = 1;
        run_until_idle(400, "t037");
        chk("t037_nreq", 64'(n_req), 64'd16);
        chk("t037_beats", 64'(n_pop), 64'd16);
        chk("t037_done", 64'(done_cnt - dc0), 64'd1);

        // Random backpressure on requests
        dc0 = done_cnt;
        tready_mode = 1; resp_mode = 1; dr_mode = 2;
        launch(32'h0004_0000, mk_shape(3, 2, 8));
        run_until_idle(2000, "t038");
        chk("t038_nreq", 64'(dut_addr_log.size()), 64'(model_addrs.size()));
        chk("t038_done", 64'(done_cnt - dc0), 64'd1);

        // Address wrap-around
        tready_mode = 0; resp_mode = 0; dr_mode = 1;
        launch(32'hFFFF_FFF8, mk_shape(2, 1, 4));
        run_until_idle(200, "t039");
        chk("t039_nreq", 64'(dut_addr_log.size()), 64'd2);
        if (dut_addr_log.size() == 2) begin
            chk("t039_addr0", 64'(dut_addr_log[0]), 64'h0000_0000_FFFF_FFF8);
            chk("t039_addr1", 64'(dut_addr_log[1]), 64'h0);
        end

        // Reset mid-read, then a clean restart
        dr_mode = 2; resp_mode = 1;
        launch(32'h5000, mk_shape(4, 1, 8));
        k = 0;
        while (n_pop < 3 && k < 300) begin
            step();
            k++;
        end
        chk("t040_progress", 64'(n_pop >= 3), 64'd1);
        dc0 = done_cnt;
        rst = 1;
        #1;
        chk_all_zero("rst_mid");
        step(); step();
        rst = 0;
        step(); step();
        chk("t040_no_done", 64'(done_cnt - dc0), 64'd0);
        dr_mode = 1;
        launch(32'h5000, mk_shape(4, 1, 8));
        run_until_idle(400, "t040");
        chk("t040_nreq", 64'(n_req), 64'd8);
        chk("t040_beats", 64'(n_pop), 64'd8);
        chk("t040_done", 64'(done_cnt - dc0), 64'd1);

        // Randomized shapes and handshake timing
        for (int t = 0; t < 6; t++) begin
            w = $urandom_range(1, 5);
            h = $urandom_range(1, 3);
            c = N_KERNEL * $urandom_range(1, 4);
            tready_mode = $urandom_range(0, 1);
            resp_mode   = $urandom_range(0, 1);
            dr_mode     = $urandom_range(1, 2);
            dc0 = done_cnt;
            launch($urandom, mk_shape(w, h, c));
            run_until_idle(3000, "rand");
            chk("rand_nreq", 64'(n_req), 64'(w * h * (c / N_KERNEL)));
            chk("rand_beats", 64'(n_pop), 64'(w * h * (c / N_KERNEL)));
            chk("rand_done", 64'(done_cnt - dc0), 64'd1);
        end
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
